// File: rtl/multiword_adder_seq.sv
// Sequential WORDS x 16-bit adder driving one prefix_adder_16bit limb per cycle.
// Optional build macro MWADD_OVF_EN enables the registered signed-overflow flag.

module prefix_adder_16bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] Sum,
    output logic        Cout
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] g_next;
    logic [15:0] p_next;
    logic [16:0] c;

    // Kogge-Stone prefix tree: four doubling levels, then fold in Cin per bit.
    always_comb begin
        g      = A & B;
        p      = A ^ B;
        g_next = '0;
        p_next = '0;
        for (int l = 0; l < 4; l++) begin
            g_next = g | (p & (g << (1 << l)));
            p_next = p & ((p << (1 << l)) | ((16'd1 << (1 << l)) - 16'd1));
            g      = g_next;
            p      = p_next;
        end
        c = {g | (p & {16{Cin}}), Cin};
    end

    assign Sum  = (A ^ B) ^ c[15:0];
    assign Cout = c[16];
endmodule

module multiword_adder_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORDS-1:0]   A,
    input  logic [16*WORDS-1:0]   B,
    input  logic                  Cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*WORDS-1:0]   Sum,
    output logic                  Cout,
    output logic                  Overflow
);
    localparam int W  = 16 * WORDS;
    localparam int CW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t         state;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W-1:0]   sum_r;
    logic [CW-1:0]  cnt;
    logic           carry;
    logic           cout_r;
    logic           in_ready_r;
    logic           out_valid_r;
    logic [15:0]    limb_sum;
    logic           limb_cout;
`ifdef MWADD_OVF_EN
    logic           a_top;
    logic           b_top;
    logic           ovf_r;
`endif

    prefix_adder_16bit u_limb (
        .A    (op_a[15:0]),
        .B    (op_b[15:0]),
        .Cin  (carry),
        .Sum  (limb_sum),
        .Cout (limb_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            sum_r       <= '0;
            cnt         <= '0;
            carry       <= 1'b0;
            cout_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
`ifdef MWADD_OVF_EN
            a_top       <= 1'b0;
            b_top       <= 1'b0;
            ovf_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a       <= A;
                        op_b       <= B;
                        carry      <= Cin;
                        cnt        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= ADD;
`ifdef MWADD_OVF_EN
                        a_top      <= A[W-1];
                        b_top      <= B[W-1];
`endif
                    end
                end
                ADD: begin
                    // Limbs enter at the top so limb 0 ends up at the bottom after WORDS shifts.
                    sum_r <= {limb_sum, sum_r[W-1:16]};
                    carry <= limb_cout;
                    op_a  <= op_a >> 16;
                    op_b  <= op_b >> 16;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WORDS - 1)) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                        cout_r      <= limb_cout;
`ifdef MWADD_OVF_EN
                        ovf_r       <= a_top ^ b_top ^ limb_sum[15] ^ limb_cout;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign Sum       = sum_r;
    assign Cout      = cout_r;
`ifdef MWADD_OVF_EN
    assign Overflow  = ovf_r;
`else
    assign Overflow  = 1'b0;
`endif
endmodule
